// File: rtl/pid_mixer_seq.sv
// Quadcopter PID (P/I/D per axis on one shared multiplier) followed by a
// 4-motor mixer with per-motor duty saturation.
module pid_mixer_seq #(
    parameter int DW       = 24,
    parameter int GW       = 16,
    parameter int FRAC     = 8,
    parameter int OW       = 16,
    parameter int AXIS_LIM = 20000,
    parameter int DUTY_MIN = 0,
    parameter int DUTY_MAX = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            armed,
    input  logic [OW-1:0]   pwm_base,
    input  logic [3*DW-1:0] err_p,
    input  logic [3*DW-1:0] err_i,
    input  logic [3*DW-1:0] err_d,
    input  logic [3*GW-1:0] gain_p,
    input  logic [3*GW-1:0] gain_i,
    input  logic [3*GW-1:0] gain_d,
    output logic            busy,
    output logic            done,
    output logic [3:0]      sat,
    output logic [OW-1:0]   pwm_duty_1,
    output logic [OW-1:0]   pwm_duty_2,
    output logic [OW-1:0]   pwm_duty_3,
    output logic [OW-1:0]   pwm_duty_4
);

    localparam int AW = DW + GW + 3;
    localparam int MW = OW + 3;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_MIX, S_UPD} state_t;

    state_t state, state_nxt;

    logic [OW-1:0]          base_q;
    logic signed [DW-1:0]   ep_a [3];
    logic signed [DW-1:0]   ei_a [3];
    logic signed [DW-1:0]   ed_a [3];
    logic [GW-1:0]          gp_a [3];
    logic [GW-1:0]          gi_a [3];
    logic [GW-1:0]          gd_a [3];

    logic [1:0]             ax_q;
    logic [1:0]             kind_q;
    logic signed [AW-1:0]   acc;
    logic signed [MW-1:0]   term_q [3];

    logic [OW-1:0]          mix_q [4];
    logic [3:0]             mix_sat_q;

    logic signed [DW-1:0]   err_sel;
    logic [GW-1:0]          gain_sel;
    logic signed [DW+GW:0]  prod;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   shifted;
    logic signed [MW-1:0]   term_new;
    logic signed [MW-1:0]   base_s;
    logic signed [MW-1:0]   m [4];
    logic [OW-1:0]          duty_c [4];
    logic [3:0]             sat_c;

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_MAC;
            S_MAC:  if (ax_q == 2'd2 && kind_q == 2'd2) state_nxt = S_MIX;
            S_MIX:  state_nxt = S_UPD;
            S_UPD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gain is unsigned: prepend a zero so the signed multiply treats it as positive.
    always_comb begin
        err_sel  = '0;
        gain_sel = '0;
        case (kind_q)
            2'd0: begin err_sel = ep_a[ax_q]; gain_sel = gp_a[ax_q]; end
            2'd1: begin err_sel = ei_a[ax_q]; gain_sel = gi_a[ax_q]; end
            default: begin err_sel = ed_a[ax_q]; gain_sel = gd_a[ax_q]; end
        endcase
        prod    = err_sel * $signed({1'b0, gain_sel});
        acc_sum = acc + AW'(prod);
        shifted = acc_sum >>> FRAC;
        if (shifted > AW'(AXIS_LIM))
            term_new = MW'(AXIS_LIM);
        else if (shifted < -AW'(AXIS_LIM))
            term_new = -MW'(AXIS_LIM);
        else
            term_new = MW'(shifted);
    end

    always_comb begin
        base_s = $signed({3'b000, base_q});
        m[0] = base_s - term_q[0] - term_q[1] - term_q[2];
        m[1] = base_s - term_q[0] + term_q[1] + term_q[2];
        m[2] = base_s + term_q[0] - term_q[1] + term_q[2];
        m[3] = base_s + term_q[0] + term_q[1] - term_q[2];
        sat_c = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            duty_c[n] = OW'(m[n]);
            if (m[n] < MW'(DUTY_MIN)) begin
                duty_c[n] = OW'(DUTY_MIN);
                sat_c[n]  = 1'b1;
            end else if (m[n] > MW'(DUTY_MAX)) begin
                duty_c[n] = OW'(DUTY_MAX);
                sat_c[n]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            ax_q       <= '0;
            kind_q     <= '0;
            acc        <= '0;
            mix_sat_q  <= '0;
            done       <= 1'b0;
            sat        <= '0;
            pwm_duty_1 <= '0;
            pwm_duty_2 <= '0;
            pwm_duty_3 <= '0;
            pwm_duty_4 <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                ep_a[i]   <= '0;
                ei_a[i]   <= '0;
                ed_a[i]   <= '0;
                gp_a[i]   <= '0;
                gi_a[i]   <= '0;
                gd_a[i]   <= '0;
                term_q[i] <= '0;
            end
            for (int unsigned n = 0; n < 4; n++) mix_q[n] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    base_q <= pwm_base;
                    ax_q   <= '0;
                    kind_q <= '0;
                    acc    <= '0;
                    for (int unsigned i = 0; i < 3; i++) begin
                        ep_a[i] <= err_p[i*DW +: DW];
                        ei_a[i] <= err_i[i*DW +: DW];
                        ed_a[i] <= err_d[i*DW +: DW];
                        gp_a[i] <= gain_p[i*GW +: GW];
                        gi_a[i] <= gain_i[i*GW +: GW];
                        gd_a[i] <= gain_d[i*GW +: GW];
                    end
                end
                S_MAC: begin
                    if (kind_q == 2'd2) begin
                        term_q[ax_q] <= term_new;
                        acc          <= '0;
                        kind_q       <= '0;
                        if (ax_q != 2'd2) ax_q <= ax_q + 2'd1;
                    end else begin
                        acc    <= acc_sum;
                        kind_q <= kind_q + 2'd1;
                    end
                end
                S_MIX: begin
                    for (int unsigned n = 0; n < 4; n++)
                        mix_q[n] <= armed ? duty_c[n] : OW'(DUTY_MIN);
                    mix_sat_q <= armed ? sat_c : 4'b0000;
                end
                S_UPD: begin
                    pwm_duty_1 <= mix_q[0];
                    pwm_duty_2 <= mix_q[1];
                    pwm_duty_3 <= mix_q[2];
                    pwm_duty_4 <= mix_q[3];
                    sat        <= mix_sat_q;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mixer_seq.sv
// Scoreboard bench for pid_mixer_seq: a reference model produces the expected
// duties/sat at start time; they are compared when done pulses.
module tb_pid_mixer_seq;

    localparam int DW = 24;
    localparam int GW = 16;
    localparam int OW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            armed = 1'b1;
    logic [OW-1:0]   pwm_base = '0;
    logic [3*DW-1:0] err_p = '0, err_i = '0, err_d = '0;
    logic [3*GW-1:0] gain_p = '0, gain_i = '0, gain_d = '0;
    logic            busy, done;
    logic [3:0]      sat;
    logic [OW-1:0]   pwm_duty_1, pwm_duty_2, pwm_duty_3, pwm_duty_4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4*OW+3:0] sb [$];

    pid_mixer_seq #(
        .DW(DW), .GW(GW), .FRAC(8), .OW(OW),
        .AXIS_LIM(20000), .DUTY_MIN(0), .DUTY_MAX(50000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .armed(armed),
        .pwm_base(pwm_base),
        .err_p(err_p), .err_i(err_i), .err_d(err_d),
        .gain_p(gain_p), .gain_i(gain_i), .gain_d(gain_d),
        .busy(busy), .done(done), .sat(sat),
        .pwm_duty_1(pwm_duty_1), .pwm_duty_2(pwm_duty_2),
        .pwm_duty_3(pwm_duty_3), .pwm_duty_4(pwm_duty_4)
    );

    always #5 clk = ~clk;

    function automatic logic [4*OW+3:0] model();
        longint t [3];
        longint mm [4];
        longint acc;
        logic [3:0] s;
        logic [OW-1:0] d [4];
        for (int ax = 0; ax < 3; ax++) begin
            acc = longint'($signed(err_p[ax*DW +: DW])) * longint'(gain_p[ax*GW +: GW])
                + longint'($signed(err_i[ax*DW +: DW])) * longint'(gain_i[ax*GW +: GW])
                + longint'($signed(err_d[ax*DW +: DW])) * longint'(gain_d[ax*GW +: GW]);
            t[ax] = acc >>> 8;
            if (t[ax] > 20000) t[ax] = 20000;
            if (t[ax] < -20000) t[ax] = -20000;
        end
        mm[0] = longint'(pwm_base) - t[0] - t[1] - t[2];
        mm[1] = longint'(pwm_base) - t[0] + t[1] + t[2];
        mm[2] = longint'(pwm_base) + t[0] - t[1] + t[2];
        mm[3] = longint'(pwm_base) + t[0] + t[1] - t[2];
        s = '0;
        for (int n = 0; n < 4; n++) begin
            if (mm[n] < 0) begin mm[n] = 0; s[n] = 1'b1; end
            if (mm[n] > 50000) begin mm[n] = 50000; s[n] = 1'b1; end
            d[n] = armed ? OW'(mm[n]) : '0;
        end
        if (!armed) s = '0;
        return {s, d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [4*OW+3:0] observed();
        return {sat, pwm_duty_4, pwm_duty_3, pwm_duty_2, pwm_duty_1};
    endfunction

    task automatic clear_inputs();
        err_p = '0; err_i = '0; err_d = '0;
        gain_p = {3{16'd256}}; gain_i = {3{16'd256}}; gain_d = {3{16'd256}};
        armed = 1'b1;
    endtask

    task automatic drive_start(input bit now);
        if (!now) @(negedge clk);
        start = 1'b1;
        sb.push_back(model());
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bc, output bit to);
        cyc = 0; bc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        to = (done !== 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, observed()} !== '0) begin
            n_bad++;
            $display("FAIL reset: got %h expected 0", {busy, done, observed()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int cyc, bc; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd1500;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL zero_timeout: done not seen within %0d cycles", cyc); end
        n_cmp++;
        if (cyc != 11) begin n_bad++; $display("FAIL zero_latency: got %0d expected 11", cyc); end
        n_cmp++;
        if (bc != 11) begin n_bad++; $display("FAIL zero_busy: got %0d expected 11", bc); end
        exp = sb.pop_front();
        n_cmp++;
        if (observed() !== exp) begin n_bad++; $display("FAIL zero_result: got %h expected %h", observed(), exp); end
        @(negedge clk);
        n_cmp++;
        if ({done, observed()} !== {1'b0, exp}) begin
            n_bad++;
            $display("FAIL done_pulse_hold: got %h expected %h", {done, observed()}, {1'b0, exp});
        end
    endtask

    task automatic test_pitch();
        int cyc, bc; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd1500;
        err_p[0 +: DW] = 24'sd4;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL pitch_p: got %h expected %h timeout=%0d", observed(), exp, to);
        end
        // Floor behaviour of the arithmetic shift: -1 * 1 >>> 8 gives -1.
        err_p[0 +: DW] = -24'sd1;
        gain_p[0 +: GW] = 16'd1;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL pitch_floor: got %h expected %h timeout=%0d", observed(), exp, to);
        end
    endtask

    task automatic test_saturation();
        int cyc, bc; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd49990;
        err_p[DW +: DW] = 24'sd100;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL sat_high: got %h expected %h timeout=%0d", observed(), exp, to);
        end
        clear_inputs();
        pwm_base = 16'd10;
        err_p[2*DW +: DW] = 24'sd50;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL sat_low: got %h expected %h timeout=%0d", observed(), exp, to);
        end
    endtask

    task automatic test_clamp_disarm();
        int cyc, bc; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd1500;
        err_p[0 +: DW] = 24'h7FFFFF;
        gain_p[0 +: GW] = 16'hFFFF;
        err_i[DW +: DW] = -24'sd3000;
        err_d[2*DW +: DW] = 24'sd777;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL axis_clamp: got %h expected %h timeout=%0d", observed(), exp, to);
        end
        armed = 1'b0;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL disarmed: got %h expected %h timeout=%0d", observed(), exp, to);
        end
    endtask

    task automatic test_busy_start();
        int cyc, bc, extra; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd3000;
        err_p[DW +: DW] = -24'sd1200;
        err_d[0 +: DW] = 24'sd640;
        drive_start(1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        pwm_base = 16'd7;
        err_p = '1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc, to);
        n_cmp++;
        if (to || cyc + 5 != 11) begin
            n_bad++; $display("FAIL busy_start_latency: got %0d expected 11 timeout=%0d", cyc + 5, to);
        end
        exp = sb.pop_front();
        n_cmp++;
        if (observed() !== exp) begin n_bad++; $display("FAIL busy_start_result: got %h expected %h", observed(), exp); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_bad++; $display("FAIL busy_start_single_done: got %0d extra expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd20000;
        err_p[2*DW +: DW] = 24'sd900;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL b2b_first: got %h expected %h timeout=%0d", observed(), exp, to);
        end
        pwm_base = 16'd25000;
        err_i[0 +: DW] = 24'sd12345;
        drive_start(1'b1);
        wait_done(cyc, bc, to);
        n_cmp++;
        if (to || cyc != 11) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 11 timeout=%0d", cyc, to); end
        exp = sb.pop_front();
        n_cmp++;
        if (observed() !== exp) begin n_bad++; $display("FAIL b2b_second: got %h expected %h", observed(), exp); end
    endtask

    task automatic test_reset_midrun();
        int cyc, bc; bit to; logic [4*OW+3:0] exp;
        clear_inputs();
        pwm_base = 16'd1500;
        err_p[0 +: DW] = 24'sd4;
        drive_start(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, observed()} !== '0) begin
            n_bad++; $display("FAIL midrun_reset: got %h expected 0", {busy, done, observed()});
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(1'b0);
        wait_done(cyc, bc, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || observed() !== exp) begin
            n_bad++; $display("FAIL after_reset_run: got %h expected %h timeout=%0d", observed(), exp, to);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_pitch();
        test_saturation();
        test_clamp_disarm();
        test_busy_start();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
